sum_window_accumulator: RTL
===========================

# sum_window_accumulator

Downstream consumer of the byte-wide adder stage. Accepts one 8-bit sum per valid/ready handshake, accumulates a fixed window of WINDOW samples into a saturating accumulator, then presents the window total on a valid/ready output port until it is taken. Sits between the combinational adder output and the output pin mux / readout logic of the design.

## Interface
- WIDTH, 8: input sample width (unsigned).
- ACC_W, 16: accumulator and output width; ACC_W >= WIDTH.
- WINDOW, 4: samples per window; WINDOW >= 2. Counter width is clog2(WINDOW+1).

- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush: drops partial window and any pending result.
- in_data  input  WIDTH  unsigned sample from the adder stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- out_data  output  ACC_W  window total, saturated.
- out_valid  output  1  out_data holds a completed window.
- out_ready  input  1  consumer takes out_data this cycle.
- out_sat  output  1  saturation occurred in the window shown on out_data; valid with out_valid.
- sample_cnt  output  clog2(WINDOW+1)  samples accepted in the current window.

## Operation
- Two states: ACC (collecting) and HOLD (result pending).
- ACC: in_ready=1, out_valid=0. A sample is accepted when in_valid && in_ready.
- Each accepted sample: acc <= min(acc + zero-extended in_data, 2^ACC_W-1); sat flag set if the unclamped sum exceeds 2^ACC_W-1; sat is sticky for the window. Internal add is ACC_W+1 bits.
- On acceptance of the WINDOW-th sample: state -> HOLD, out_data <= the final (saturated) total including that sample, out_sat <= final sat flag, sample_cnt <= WINDOW.
- HOLD: in_ready=0, out_valid=1, out_data/out_sat stable. in_valid is ignored.
- HOLD with out_ready=1: result consumed; next cycle state ACC, acc=0, sat=0, sample_cnt=0, out_valid=0, in_ready=1.
- out_ready while in ACC: no effect.
- No bypass: a sample offered in the cycle a result is consumed is not accepted.
- Priority: rst > clear > normal operation. clear in any state: state ACC, acc=0, sat=0, sample_cnt=0, out_valid=0; a sample presented the same cycle is discarded; a pending result is lost even if out_ready=1.
- in_data values when in_valid=0 have no effect.

## Timing
- Reset values (cycle after rst high): state ACC, in_ready=1, out_valid=0, out_data=0, out_sat=0, sample_cnt=0, internal acc=0.
- in_ready and out_valid are registered state decodes; neither depends combinationally on in_valid or out_ready.
- Latency: out_valid rises the cycle after the WINDOW-th acceptance.
- Throughput: one window per WINDOW+1 cycles minimum (WINDOW accept cycles + 1 HOLD cycle with out_ready=1).
- Back-pressure: out_ready held low keeps HOLD indefinitely, out_data unchanged.
- rst or clear asserted mid-window or in HOLD takes effect at the next edge; no partial result ever appears on out_valid.
- out_data retains its last value after consumption (not cleared) until the next window completes; only rst clears it.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1, in_data=0xFF -> in_ready=1, out_valid=0, out_data=0, sample_cnt=0; no sample counted.
- Basic window (defaults): samples 10, 20, 30, 40 back-to-back, out_ready=1 -> out_valid high exactly one cycle after 4th accept, out_data=100, out_sat=0; in_ready low that cycle, high the next.
- Back-pressure + gapped input: samples 0xFF x4 with in_valid toggling, out_ready=0 for 5 cycles -> out_data=1020 held stable 5+ cycles, in_ready=0 throughout, extra in_valid pulses not counted; release out_ready -> next window starts from 0.
- Saturation (ACC_W=10, WINDOW=8): eight samples of 0xFF -> out_data=1023, out_sat=1; following window of eight 1s -> out_data=8, out_sat=0.
- Clear mid-window: accept 5, 6, then clear with in_valid=1, in_data=7 -> sample_cnt=0, 7 discarded; then 1,2,3,4 -> out_data=10.
- Clear in HOLD with out_ready=1: result 100 pending, assert clear -> out_valid=0 next cycle, no handshake completes, new window starts from 0.

Source files
------------

// File: rtl/sum_window_accumulator.sv
// rtl/sum_window_accumulator.sv - saturating windowed sum of adder-stage samples
// Collects WINDOW samples per valid/ready handshake and holds the window total until consumed.
module sum_window_accumulator #(
  parameter int WIDTH  = 8,
  parameter int ACC_W  = 16,
  parameter int WINDOW = 4,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sat,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             sat;
  logic [ACC_W:0]   sum_wide;
  logic             overflow;
  logic [ACC_W-1:0] sum_clamped;
  logic             accept;
  logic             last_sample;

  // One extra bit catches the carry so the clamp never wraps.
  always_comb begin
    sum_wide    = {1'b0, acc} + {{(ACC_W + 1 - WIDTH){1'b0}}, in_data};
    overflow    = sum_wide[ACC_W];
    sum_clamped = overflow ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    accept      = in_valid && in_ready;
    last_sample = (sample_cnt == CNT_W'(WINDOW - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACC;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      acc        <= '0;
      sat        <= 1'b0;
      sample_cnt <= '0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else if (clear) begin
      // out_data is deliberately kept; only rst wipes the last shown total.
      state      <= ACC;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      acc        <= '0;
      sat        <= 1'b0;
      sample_cnt <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (last_sample) begin
              state      <= HOLD;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              out_data   <= sum_clamped;
              out_sat    <= sat | overflow;
              sample_cnt <= CNT_W'(WINDOW);
            end else begin
              acc        <= sum_clamped;
              sat        <= sat | overflow;
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= ACC;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            acc        <= '0;
            sat        <= 1'b0;
            sample_cnt <= '0;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
